// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared constants and the fetch-control priority decode for
//               the MIPS32 instruction fetch stage.
//               RESET_PC_DEFAULT, PC_INC, DATA_W, WORD_SHIFT (byte<->word).
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam int          DATA_W           = 32;
  localparam int          WORD_SHIFT       = 2;

  // Which source drives the fetch this cycle, in priority order.
  typedef enum logic [1:0] {
    SEL_RESET    = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_HOLD     = 2'd2,
    SEL_SEQ      = 2'd3
  } fetch_sel_e;

  // Single definition of the priority so the address mux and the PC
  // registers can never disagree: reset > redirect > stall > sequential.
  function automatic fetch_sel_e fetch_sel(input logic rst,
                                           input logic redirect,
                                           input logic stall);
    if (rst)           return SEL_RESET;
    else if (redirect) return SEL_REDIRECT;
    else if (stall)    return SEL_HOLD;
    else               return SEL_SEQ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface   : instr_fetch_if
// Description : Bundles the fetch stage's control inputs, ROM port and the
//               instruction output toward decode.
//               slave  : fetch-stage view (drives rom_addr and instr_*).
//               master : environment view (drives stall/redirect/rom_data).
// Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [31:0]       instr_pc;
  logic [31:0]       instr_pc_plus4;
  logic              instr_valid;
  logic              fetch_fault;

  modport slave (
    input  stall, redirect, redirect_pc, rom_data,
    output rom_addr, instr, instr_pc, instr_pc_plus4, instr_valid, fetch_fault
  );

  modport master (
    output stall, redirect, redirect_pc, rom_data,
    input  rom_addr, instr, instr_pc, instr_pc_plus4, instr_valid, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program-counter state of the fetch stage: pc (next PC to
//               issue), fpc (PC whose word is on the ROM data bus) and the
//               valid flag, with the next-PC priority logic.
// Ports       : clk, rst        clock / synchronous active-high reset
//               stall_i         hold all state
//               redirect_i      restart the stream at redirect_pc_i
//               redirect_pc_i   byte address of the redirect target
//               pc_o, fpc_o     issue PC / fetched PC
//               fvalid_o        fetched word is meaningful
// Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall_i,
  input  wire logic        redirect_i,
  input  wire logic [31:0] redirect_pc_i,
  output logic      [31:0] pc_o,
  output logic      [31:0] fpc_o,
  output logic             fvalid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        fvalid_q, fvalid_d;

  always_comb begin
    pc_d     = pc_q;
    fpc_d    = fpc_q;
    fvalid_d = fvalid_q;
    case (fetch_sel(rst, redirect_i, stall_i))
      SEL_RESET: begin
        pc_d     = RESET_PC;
        fpc_d    = RESET_PC;
        fvalid_d = 1'b0;
      end
      // Target is issued this edge, so the sequential successor is next.
      SEL_REDIRECT: begin
        fpc_d    = redirect_pc_i;
        pc_d     = redirect_pc_i + PC_INC;
        fvalid_d = 1'b1;
      end
      SEL_HOLD: begin
        pc_d     = pc_q;
      end
      SEL_SEQ: begin
        fpc_d    = pc_q;
        pc_d     = pc_q + PC_INC;
        fvalid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fpc_q    <= RESET_PC;
      fvalid_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      fpc_q    <= fpc_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign pc_o     = pc_q;
  assign fpc_o    = fpc_q;
  assign fvalid_o = fvalid_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : MIPS32 instruction fetch stage in front of a synchronous
//               instruction ROM. Drives the ROM word address, pairs each
//               returned word with its PC and presents it to decode.
//               Supports stall (hold) and zero-bubble redirect.
// Ports       : clk, rst   clock / synchronous active-high reset
//               bus        instr_fetch_if.slave (controls, ROM port, output)
// Options     : FETCH_ALIGN_CHECK_EN - when defined, fetch_fault flags an
//               issued PC with bits [1:0] != 0; otherwise fetch_fault = 0.
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input wire logic     clk,
  input wire logic     rst,
  instr_fetch_if.slave bus
);

  logic [31:0] w_pc;
  logic [31:0] w_fpc;
  logic        w_fvalid;
  logic [31:0] w_issue_pc;
  logic        w_unused_addr_bits;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (bus.stall),
    .redirect_i    (bus.redirect),
    .redirect_pc_i (bus.redirect_pc),
    .pc_o          (w_pc),
    .fpc_o         (w_fpc),
    .fvalid_o      (w_fvalid)
  );

  // Byte PC issued to the ROM this cycle. On stall the held word is
  // re-read so the ROM output stays unchanged.
  always_comb begin
    w_issue_pc = w_pc;
    case (fetch_sel(rst, bus.redirect, bus.stall))
      SEL_RESET:    w_issue_pc = RESET_PC;
      SEL_REDIRECT: w_issue_pc = bus.redirect_pc;
      SEL_HOLD:     w_issue_pc = w_fpc;
      SEL_SEQ:      w_issue_pc = w_pc;
    endcase
  end

  // Upper PC bits are dropped so the ROM aliases across the 4 GiB space.
  assign bus.rom_addr       = w_issue_pc[ADDR_W+1:WORD_SHIFT];
  assign w_unused_addr_bits = ^{w_issue_pc[31:ADDR_W+2], w_issue_pc[1:0]};

  assign bus.instr          = bus.rom_data;
  assign bus.instr_pc       = w_fpc;
  assign bus.instr_pc_plus4 = w_fpc + PC_INC;
  assign bus.instr_valid    = w_fvalid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  // Tracks the alignment of whatever PC becomes fpc on this edge; held
  // whenever fpc is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (bus.redirect || !bus.stall) begin
      fault_q <= |w_issue_pc[1:0];
    end
  end

  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a behavioural ROM
//               (word i = 32'h1000_0000 + i) and a fetch-stream model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;
  import mips_pkg::*;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous ROM.
  always @(posedge clk) bus.rom_data <= 32'h1000_0000 + {22'd0, bus.rom_addr};

  // Reference model of the visible stream:
  // m_pc    - PC currently presented to decode
  // m_seq   - PC that a plain advance would present next
  logic [31:0] m_pc, m_seq;
  logic        m_valid, m_fault;

  function automatic logic [9:0] rom_index(input logic [31:0] byte_pc);
    return byte_pc[11:2];
  endfunction

  function automatic logic [9:0] exp_addr();
    logic [31:0] b;
    if (rst)               b = RST_PC;
    else if (bus.redirect) b = bus.redirect_pc;
    else if (bus.stall)    b = m_pc;
    else                   b = m_seq;
    return rom_index(b);
  endfunction

  function automatic logic [97:0] exp_out();
    logic f;
`ifdef FETCH_ALIGN_CHECK_EN
    f = m_fault;
`else
    f = 1'b0;
`endif
    return {m_valid, m_pc, m_pc + 32'd4, 32'h1000_0000 + {22'd0, rom_index(m_pc)}, f};
  endfunction

  function automatic logic [97:0] got_out();
    return {bus.instr_valid, bus.instr_pc, bus.instr_pc_plus4, bus.instr, bus.fetch_fault};
  endfunction

  // Apply inputs at the falling edge and let combinational paths settle.
  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] p);
    rst             = r;
    bus.stall       = s;
    bus.redirect    = d;
    bus.redirect_pc = p;
    #1;
  endtask

  // One rising edge, advancing the model from the applied inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_pc = RST_PC; m_seq = RST_PC; m_fault = 1'b0;
    end else if (bus.redirect) begin
      m_valid = 1'b1; m_pc = bus.redirect_pc; m_seq = bus.redirect_pc + 32'd4;
      m_fault = (bus.redirect_pc[1:0] != 2'b00);
    end else if (!bus.stall) begin
      m_valid = 1'b1; m_pc = m_seq; m_seq = m_seq + 32'd4;
      m_fault = (m_pc[1:0] != 2'b00);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      checks++;
      if (bus.rom_addr !== 10'd0) begin
        failures++;
        $display("FAIL reset_addr: got %h want %h", bus.rom_addr, 10'd0);
      end
      tick();
      checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr_pc_plus4, bus.fetch_fault} !==
          {1'b0, 32'h0, 32'h4, 1'b0}) begin
        failures++;
        $display("FAIL reset_state: got v=%b pc=%h pc4=%h f=%b want v=0 pc=0 pc4=4 f=0",
                 bus.instr_valid, bus.instr_pc, bus.instr_pc_plus4, bus.fetch_fault);
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want_pc [3];
    logic [31:0] want_in [3];
    want_pc = '{32'h0, 32'h4, 32'h8};
    want_in = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_cycle_valid: got %b want 0", bus.instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, want_pc[i], want_in[i]}) begin
        failures++;
        $display("FAIL seq_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, want_pc[i], want_in[i]);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (bus.rom_addr !== 10'd2) begin
        failures++;
        $display("FAIL stall_addr_%0d: got %h want %h", i, bus.rom_addr, 10'd2);
      end
      tick();
      checks++;
      if ({bus.instr_pc, bus.instr} !== {32'h8, 32'h1000_0002}) begin
        failures++;
        $display("FAIL stall_hold_%0d: got pc=%h instr=%h want pc=8 instr=10000002",
                 i, bus.instr_pc, bus.instr);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr} !== {32'hC, 32'h1000_0003}) begin
      failures++;
      $display("FAIL stall_release: got pc=%h instr=%h want pc=c instr=10000003",
               bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    tick();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'h40, 32'h1000_0010}) begin
      failures++;
      $display("FAIL redirect_target: got pc=%h instr=%h want pc=40 instr=10000010",
               bus.instr_pc, bus.instr);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr_pc_plus4} !== {32'h44, 32'h48}) begin
      failures++;
      $display("FAIL redirect_next: got pc=%h pc4=%h want pc=44 pc4=48",
               bus.instr_pc, bus.instr_pc_plus4);
    end
    // Redirect wins over a simultaneous stall.
    drive(1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr} !== {32'h80, 32'h1000_0020}) begin
      failures++;
      $display("FAIL redirect_over_stall: got pc=%h instr=%h want pc=80 instr=10000020",
               bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFF8);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr} !== {32'hFFC, 32'h1000_03FF}) begin
      failures++;
      $display("FAIL wrap_top: got pc=%h instr=%h want pc=ffc instr=100003ff",
               bus.instr_pc, bus.instr);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.rom_addr !== 10'd0) begin
      failures++;
      $display("FAIL wrap_addr: got %h want 000", bus.rom_addr);
    end
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr} !== {32'h1000, 32'h1000_0000}) begin
      failures++;
      $display("FAIL wrap_alias: got pc=%h instr=%h want pc=1000 instr=10000000",
               bus.instr_pc, bus.instr);
    end
    // PC arithmetic wraps modulo 2^32.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr_pc_plus4, bus.instr} !== {32'hFFFF_FFFC, 32'h0, 32'h1000_03FF}) begin
      failures++;
      $display("FAIL wrap_32: got pc=%h pc4=%h instr=%h want pc=fffffffc pc4=0 instr=100003ff",
               bus.instr_pc, bus.instr_pc_plus4, bus.instr);
    end
  endtask

  task automatic test_align();
    logic want_f;
`ifdef FETCH_ALIGN_CHECK_EN
    want_f = 1'b1;
`else
    want_f = 1'b0;
`endif
    drive(1'b0, 1'b0, 1'b1, 32'h42);
    tick();
    checks++;
    if ({bus.instr_pc, bus.instr, bus.fetch_fault} !== {32'h42, 32'h1000_0010, want_f}) begin
      failures++;
      $display("FAIL align_set: got pc=%h instr=%h f=%b want pc=42 instr=10000010 f=%b",
               bus.instr_pc, bus.instr, bus.fetch_fault, want_f);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.instr_pc, bus.fetch_fault} !== {32'h42, want_f}) begin
      failures++;
      $display("FAIL align_hold: got pc=%h f=%b want pc=42 f=%b",
               bus.instr_pc, bus.fetch_fault, want_f);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h48);
    tick();
    checks++;
    if ({bus.instr_pc, bus.fetch_fault} !== {32'h48, 1'b0}) begin
      failures++;
      $display("FAIL align_clear: got pc=%h f=%b want pc=48 f=0",
               bus.instr_pc, bus.fetch_fault);
    end
  endtask

  task automatic test_random();
    logic        r, s, d;
    logic [31:0] p;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 5) == 0);
      p = $urandom;
      if ($urandom_range(0, 1) == 1) p[1:0] = 2'b00;
      drive(r, s, d, p);
      checks++;
      if (bus.rom_addr !== exp_addr()) begin
        failures++;
        $display("FAIL rand_addr_%0d: got %h want %h", i, bus.rom_addr, exp_addr());
      end
      tick();
      checks++;
      if (got_out() !== exp_out()) begin
        failures++;
        $display("FAIL rand_out_%0d: got %h want %h", i, got_out(), exp_out());
      end
    end
  endtask

  initial begin
    m_pc = RST_PC; m_seq = RST_PC; m_valid = 1'b0; m_fault = 1'b0;
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS32 core, sitting directly upstream of the synchronous instruction ROM. It owns the program counter and drives the ROM word address. It pairs each ROM read word with the PC it was fetched from and presents that pair to the decode stage as a valid-tagged instruction. It also handles pipeline stall (hold) and branch/jump redirect.

## Interface
- ADDR_W, 10, ROM word-address width; 2^ADDR_W words.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- Clock  in  1  rising-edge clock for all state.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold current output instruction; PC does not advance.
- Redirect  in  1  replace the fetch stream with RedirectPC.
- RedirectPC  in  32  byte address of the redirect target.
- RomAddress  out  ADDR_W  word address to ROM; the ROM registers it on the rising edge.
- RomData  in  DATA_W  ROM read data, valid the cycle after its address.
- InstrOut  out  DATA_W  instruction to decode; equals RomData.
- InstrPC  out  32  byte PC of InstrOut.
- InstrPCPlus4  out  32  InstrPC + 4, mod 2^32.
- InstrValid  out  1  InstrOut/InstrPC are meaningful.
- FetchFault  out  1  misaligned fetch flag (see Configuration).

## Operation
- State:
  - pc (32b): next PC to issue.
  - fpc (32b): PC whose word is on RomData.
  - fvalid (1b).
- Address mux, combinational, in priority order:
  - Reset: RomAddress = RESET_PC[ADDR_W+1:2].
  - Redirect: RedirectPC[ADDR_W+1:2].
  - Stall: fpc[ADDR_W+1:2], re-reading the held word so RomData is unchanged.
  - Otherwise: pc[ADDR_W+1:2].
- Update on each rising edge, in priority order:
  - Reset: pc<=RESET_PC, fpc<=RESET_PC, fvalid<=0.
  - Redirect: fpc<=RedirectPC, pc<=RedirectPC+4, fvalid<=1.
  - Stall: all state held.
  - Otherwise: fpc<=pc, pc<=pc+4, fvalid<=1.
- Outputs:
  - InstrOut = RomData.
  - InstrPC = fpc.
  - InstrPCPlus4 = fpc+4.
  - InstrValid = fvalid.
- Arithmetic and wrap-around:
  - All PC arithmetic is 32-bit and wraps modulo 2^32.
  - PC bits above ADDR_W+1 are ignored for addressing, so the ROM aliases/wraps.
- Redirect beats Stall when both are asserted in the same cycle.
- The instruction presented in a Redirect cycle is wrong-path. The redirect source squashes it; decode must ignore that cycle.
- Reset asserted mid-stream takes effect at the next edge regardless of Stall/Redirect.

## Timing
- Reset values (after a reset edge):
  - InstrValid=0, InstrPC=RESET_PC, InstrPCPlus4=RESET_PC+4.
  - FetchFault=0.
  - RomAddress=RESET_PC word.
- Fetch latency: a PC issued at edge k appears on InstrOut/InstrPC during cycle k+1.
- Throughput: one instruction per cycle when not stalled.
- Stall: outputs are stable for every stalled cycle and the cycle after the stall drops. The next sequential instruction appears one cycle after Stall deasserts.
- Redirect: zero bubbles. The target instruction is valid in the cycle immediately after the Redirect edge.
- First fetch: the first edge with Reset low issues RESET_PC. InstrValid rises one cycle later.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - FetchFault is registered alongside fpc.
  - It is set when the issued PC has bits [1:0] != 0 (only possible via RedirectPC).
  - It is cleared by the next non-stalled issue of an aligned PC or by Reset.
  - It is held during Stall.
- FETCH_ALIGN_CHECK_EN undefined:
  - FetchFault is tied to 0.
  - Bits [1:0] of RedirectPC are ignored by addressing but still appear in InstrPC.

## Structure
- Shared package mips_pkg:
  - RESET_PC default.
  - PC_INC=4.
  - DATA_W=32.
  - Word/byte address conversion constant (shift 2).
- One sub-module, fetch_pc_reg: the pc/fpc/fvalid registers plus next-PC priority logic.
- The top level holds the address mux, output assignment and the optional fault flag.

## Test plan
Behavioural ROM model: word i holds 32'h1000_0000+i.
- Reset for 2 cycles, then release → InstrValid=0 in the first cycle; then InstrPC=0,4,8 with InstrOut=32'h1000_0000, _0001, _0002 on consecutive cycles.
- Stall for 3 cycles while InstrPC=8 → InstrPC=8 and InstrOut=32'h1000_0002 held for all 3 cycles; InstrPC=12 in the cycle after Stall drops.
- Redirect with RedirectPC=32'h40 → next cycle InstrPC=32'h40, InstrOut=32'h1000_0010; following cycle InstrPC=32'h44.
- Redirect and Stall together, RedirectPC=32'h80 → Redirect wins: next InstrPC=32'h80, InstrOut=32'h1000_0020.
- PC reaches 32'hFFC (ADDR_W=10), then advances → InstrPC=32'h1000, RomAddress=0, InstrOut=32'h1000_0000 (alias wrap).
- With FETCH_ALIGN_CHECK_EN defined, RedirectPC=32'h42 → FetchFault=1 alongside InstrPC=32'h42; cleared after a Redirect to 32'h48.
